// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter for the shared memory bus (data RAM plus
// UART slave mux). Master A is the debug probe, master B the multicycle core.
// Ownership moves by request/grant with a burst limit, so a busy owner cannot
// starve the other master. Read responses are tagged with the master that
// issued the read, so a response still reaches A after ownership passes to B.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   a_req/a_addr/a_we/a_rd   master A command (a_mask, a_wdata alongside)
//   a_gnt, a_rvalid          master A grant (registered), read data valid
//   b_*                      same set for master B
//   rdata                    read data broadcast to both masters (= s_rdata)
//   s_addr/s_we/s_rd         slave-side command from the current owner
//   s_mask/s_wdata           slave-side byte mask and write data
//   s_rdata                  slave read data, READ_LATENCY cycles after s_rd
module mem_bus_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 8,
  parameter int A_PRIORITY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic              a_rd,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic              b_rd,
  input  logic [3:0]        b_mask,
  input  logic [31:0]       b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_we,
  output logic              s_rd,
  output logic [3:0]        s_mask,
  output logic [31:0]       s_wdata,
  input  logic [31:0]       s_rdata
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic [7:0] burst_cnt, burst_cnt_nxt;
  logic       last_b, last_b_nxt;    // 1: B was the last owner
  logic       a_beat, b_beat;

  logic [READ_LATENCY-1:0] pipe_vld, pipe_id;   // pipe_id 1: read issued by B
  logic [READ_LATENCY:0]   vld_shift, id_shift;

  assign a_gnt  = (state == OWN_A);
  assign b_gnt  = (state == OWN_B);
  assign a_beat = a_gnt & a_req;
  assign b_beat = b_gnt & b_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_b    <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      last_b    <= last_b_nxt;
    end
  end

  // A count that saturated while the other master was quiet still hands
  // over on the next beat once the other master starts requesting.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    last_b_nxt    = last_b;
    case (state)
      IDLE: begin
        if (a_req && b_req)
          state_nxt = (A_PRIORITY != 0 || last_b) ? OWN_A : OWN_B;
        else if (a_req)
          state_nxt = OWN_A;
        else if (b_req)
          state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!a_req) begin
          state_nxt     = b_req ? OWN_B : IDLE;
          burst_cnt_nxt = '0;
          last_b_nxt    = 1'b0;
        end else if (b_req && burst_cnt >= BURST_LAST) begin
          state_nxt     = OWN_B;
          burst_cnt_nxt = '0;
          last_b_nxt    = 1'b0;
        end else if (burst_cnt != BURST_MAX) begin
          burst_cnt_nxt = burst_cnt + 8'd1;
        end
      end
      OWN_B: begin
        if (!b_req) begin
          state_nxt     = a_req ? OWN_A : IDLE;
          burst_cnt_nxt = '0;
          last_b_nxt    = 1'b1;
        end else if (a_req && burst_cnt >= BURST_LAST) begin
          state_nxt     = OWN_A;
          burst_cnt_nxt = '0;
          last_b_nxt    = 1'b1;
        end else if (burst_cnt != BURST_MAX) begin
          burst_cnt_nxt = burst_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // Command path: only the owner reaches the slave; write wins over read.
  always_comb begin
    s_addr  = '0;
    s_mask  = '0;
    s_wdata = '0;
    case (state)
      OWN_A: begin
        s_addr  = a_addr;
        s_mask  = a_mask;
        s_wdata = a_wdata;
      end
      OWN_B: begin
        s_addr  = b_addr;
        s_mask  = b_mask;
        s_wdata = b_wdata;
      end
      default: ;
    endcase
  end

  assign s_we = (a_beat & a_we) | (b_beat & b_we);
  assign s_rd = (a_beat & a_rd & ~a_we) | (b_beat & b_rd & ~b_we);

  // Response tag pipe; concatenation keeps the shift legal for depth 1.
  assign vld_shift = {pipe_vld, s_rd};
  assign id_shift  = {pipe_id, b_gnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld <= vld_shift[READ_LATENCY-1:0];
      pipe_id  <= id_shift[READ_LATENCY-1:0];
    end
  end

  assign a_rvalid = pipe_vld[READ_LATENCY-1] & ~pipe_id[READ_LATENCY-1];
  assign b_rvalid = pipe_vld[READ_LATENCY-1] &  pipe_id[READ_LATENCY-1];
  assign rdata    = s_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int AW   = 30;
  localparam int LAT0 = 1;
  localparam int MB0  = 8;
  localparam int AP0  = 1;
  localparam int LAT1 = 2;
  localparam int MB1  = 3;
  localparam int AP1  = 0;

  logic clk = 1'b0;
  logic rst;
  logic ram_init;
  always #5 clk = ~clk;

  logic          a_req, a_we, a_rd, b_req, b_we, b_rd;
  logic [AW-1:0] a_addr, b_addr;
  logic [3:0]    a_mask, b_mask;
  logic [31:0]   a_wdata, b_wdata;

  logic [1:0]    a_gnt_o, b_gnt_o, a_rv_o, b_rv_o, s_we_o, s_rd_o;
  logic [31:0]   rdata_o [2];
  logic [31:0]   s_wdata_o [2];
  logic [31:0]   s_rdata_i [2];
  logic [AW-1:0] s_addr_o [2];
  logic [3:0]    s_mask_o [2];

  mem_bus_arbiter #(.ADDR_W(AW), .READ_LATENCY(LAT0), .MAX_BURST(MB0), .A_PRIORITY(AP0)) u0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_rd(a_rd), .a_mask(a_mask), .a_wdata(a_wdata),
    .a_gnt(a_gnt_o[0]), .a_rvalid(a_rv_o[0]),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_rd(b_rd), .b_mask(b_mask), .b_wdata(b_wdata),
    .b_gnt(b_gnt_o[0]), .b_rvalid(b_rv_o[0]),
    .rdata(rdata_o[0]), .s_addr(s_addr_o[0]), .s_we(s_we_o[0]), .s_rd(s_rd_o[0]),
    .s_mask(s_mask_o[0]), .s_wdata(s_wdata_o[0]), .s_rdata(s_rdata_i[0])
  );

  mem_bus_arbiter #(.ADDR_W(AW), .READ_LATENCY(LAT1), .MAX_BURST(MB1), .A_PRIORITY(AP1)) u1 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_rd(a_rd), .a_mask(a_mask), .a_wdata(a_wdata),
    .a_gnt(a_gnt_o[1]), .a_rvalid(a_rv_o[1]),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_rd(b_rd), .b_mask(b_mask), .b_wdata(b_wdata),
    .b_gnt(b_gnt_o[1]), .b_rvalid(b_rv_o[1]),
    .rdata(rdata_o[1]), .s_addr(s_addr_o[1]), .s_we(s_we_o[1]), .s_rd(s_rd_o[1]),
    .s_mask(s_mask_o[1]), .s_wdata(s_wdata_o[1]), .s_rdata(s_rdata_i[1])
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h0 : (32'hC0DE_0000 | 32'(i));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++)
      if (m[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  // Slave environment: 64-word RAM with a read-data delay line per DUT.
  logic [31:0] env_ram [2][64];
  logic [31:0] eline [2][4];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_init) begin
        for (int i = 0; i < 64; i++) env_ram[d][i] <= init_word(i);
      end else if (s_we_o[d]) begin
        env_ram[d][s_addr_o[d][5:0]] <= merge(env_ram[d][s_addr_o[d][5:0]], s_wdata_o[d], s_mask_o[d]);
      end
      eline[d][0] <= s_rd_o[d] ? env_ram[d][s_addr_o[d][5:0]] : 32'h0BAD_F00D;
      for (int k = 1; k < 4; k++) eline[d][k] <= eline[d][k-1];
    end
  end

  always_comb begin
    s_rdata_i[0] = eline[0][LAT0-1];
    s_rdata_i[1] = eline[1][LAT1-1];
  end

  // Reference model: owner 0 none / 1 A / 2 B; beats counts beats of the
  // current tenure including the present one; responses wait in a queue.
  typedef struct {
    int          d;
    int          due;
    int          id;
    logic [31:0] data;
  } resp_t;

  resp_t       pend[$];
  int          own[2];
  int          beats[2];
  int          last[2];
  int          cyc;
  logic [31:0] mem [2][64];
  int          n_cmp;
  int          n_err;

  function automatic int lat_of(input int d);  return (d == 0) ? LAT0 : LAT1; endfunction
  function automatic int mb_of(input int d);   return (d == 0) ? MB0  : MB1;  endfunction
  function automatic int ap_of(input int d);   return (d == 0) ? AP0  : AP1;  endfunction

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  function automatic void cmd_of(input int d, output logic we, output logic rd,
                                 output logic [AW-1:0] addr, output logic [3:0] mask,
                                 output logic [31:0] wd);
    we = 1'b0; rd = 1'b0; addr = '0; mask = '0; wd = '0;
    if (own[d] == 1) begin
      we = a_req & a_we; rd = a_req & a_rd & ~a_we; addr = a_addr; mask = a_mask; wd = a_wdata;
    end else if (own[d] == 2) begin
      we = b_req & b_we; rd = b_req & b_rd & ~b_we; addr = b_addr; mask = b_mask; wd = b_wdata;
    end
  endfunction

  task automatic check_all();
    logic          we, rd, rva, rvb;
    logic [AW-1:0] addr;
    logic [3:0]    mask;
    logic [31:0]   wd, data;
    for (int d = 0; d < 2; d++) begin
      cmd_of(d, we, rd, addr, mask, wd);
      rva = 1'b0; rvb = 1'b0; data = '0;
      foreach (pend[i])
        if (pend[i].d == d && pend[i].due == cyc) begin
          rva = (pend[i].id == 1); rvb = (pend[i].id == 2); data = pend[i].data;
        end
      chk("a_gnt",   d, a_gnt_o[d],   own[d] == 1);
      chk("b_gnt",   d, b_gnt_o[d],   own[d] == 2);
      chk("s_we",    d, s_we_o[d],    we);
      chk("s_rd",    d, s_rd_o[d],    rd);
      chk("s_addr",  d, s_addr_o[d],  addr);
      chk("s_mask",  d, s_mask_o[d],  mask);
      chk("s_wdata", d, s_wdata_o[d], wd);
      chk("a_rvalid", d, a_rv_o[d],   rva);
      chk("b_rvalid", d, b_rv_o[d],   rvb);
      if (rva || rvb) chk("rdata", d, rdata_o[d], data);
    end
  endtask

  task automatic adv_all();
    logic          we, rd;
    logic [AW-1:0] addr;
    logic [3:0]    mask;
    logic [31:0]   wd;
    bit            rq[3];
    int            x, y;
    rq[0] = 1'b0; rq[1] = a_req; rq[2] = b_req;
    for (int d = 0; d < 2; d++) begin
      cmd_of(d, we, rd, addr, mask, wd);
      if (rd) pend.push_back('{d, cyc + lat_of(d), own[d], mem[d][addr[5:0]]});
      if (we) mem[d][addr[5:0]] = merge(mem[d][addr[5:0]], wd, mask);
      x = own[d];
      if (x == 0) begin
        if (rq[1] && rq[2]) own[d] = (ap_of(d) != 0 || last[d] == 2) ? 1 : 2;
        else if (rq[1]) own[d] = 1;
        else if (rq[2]) own[d] = 2;
      end else begin
        y = 3 - x;
        if (!rq[x]) begin
          own[d] = rq[y] ? y : 0; beats[d] = 0; last[d] = x;
        end else begin
          beats[d]++;
          if (rq[y] && beats[d] >= mb_of(d)) begin
            own[d] = y; beats[d] = 0; last[d] = x;
          end
        end
      end
    end
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].due <= cyc) pend.delete(i);
    cyc++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = 0; beats[d] = 0; last[d] = 2;
    end
    pend.delete();
  endtask

  task automatic cyc_chk();
    #1;
    check_all();
  endtask

  task automatic cyc_end();
    adv_all();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin cyc_chk(); cyc_end(); end
  endtask

  task automatic idle_all();
    a_req = 0; a_we = 0; a_rd = 0; b_req = 0; b_we = 0; b_rd = 0;
  endtask

  task automatic chk_reset_drop(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_a_gnt"}, d, a_gnt_o[d], 0);
      chk({tag, "_b_gnt"}, d, b_gnt_o[d], 0);
      chk({tag, "_a_rv"},  d, a_rv_o[d],  0);
      chk({tag, "_b_rv"},  d, b_rv_o[d],  0);
      chk({tag, "_s_rd"},  d, s_rd_o[d],  0);
      chk({tag, "_s_we"},  d, s_we_o[d],  0);
    end
  endtask

  task automatic async_reset();
    #1 rst = 1'b1;
    #1 chk_reset_drop("rst_drop");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int we_cnt, na, last_a, first_b;
    bit ag [14];
    bit bg [14];
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1; ram_init = 1'b1;
    idle_all();
    a_addr = '0; b_addr = '0; a_mask = '0; b_mask = '0; a_wdata = '0; b_wdata = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) mem[d][i] = init_word(i);
    model_reset();

    // Reset state
    @(negedge clk);
    run(2);
    ram_init = 1'b0;
    rst = 1'b0;

    // T1: single read from IDLE
    a_req = 1; a_rd = 1; a_addr = 30'h10; a_mask = 4'hF;
    cyc_chk(); chk("t1_no_gnt_yet", 0, a_gnt_o[0], 0); cyc_end();
    cyc_chk();
    chk("t1_gnt", 0, a_gnt_o[0], 1);
    chk("t1_s_rd", 0, s_rd_o[0], 1);
    chk("t1_s_addr", 0, s_addr_o[0], 30'h10);
    cyc_end();
    idle_all();
    cyc_chk();
    chk("t1_rvalid", 0, a_rv_o[0], 1);
    chk("t1_rdata", 0, rdata_o[0], 32'hC0DE_0010);
    cyc_end();
    run(3);

    // T4: masked write by B, then read back by A
    b_req = 1; b_we = 1; b_addr = 30'h40; b_mask = 4'b0011; b_wdata = 32'hDEAD_BEEF;
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) idle_all();
      cyc_chk(); we_cnt += int'(s_we_o[0]); cyc_end();
    end
    chk("t4_we_pulses", 0, we_cnt, 1);
    a_req = 1; a_rd = 1; a_addr = 30'h40;
    run(2);
    idle_all();
    cyc_chk();
    chk("t4_rvalid", 0, a_rv_o[0], 1);
    chk("t4_rdata", 0, rdata_o[0], 32'h0000_BEEF);
    cyc_end();
    run(3);

    // T2: simultaneous request, A priority, burst limit 8, no bubble
    a_req = 1; a_rd = 1; a_addr = 30'h10; b_req = 1; b_rd = 1; b_addr = 30'h20;
    for (int i = 0; i < 14; i++) begin
      cyc_chk(); ag[i] = a_gnt_o[0]; bg[i] = b_gnt_o[0]; cyc_end();
    end
    na = 0; last_a = -1; first_b = -1;
    for (int i = 0; i < 14; i++) begin
      if (ag[i]) begin na++; last_a = i; end
      if (bg[i] && first_b < 0) first_b = i;
    end
    chk("t2_a_beats", 0, na, 8);
    chk("t2_no_bubble", 0, first_b - last_a, 1);
    idle_all();
    run(3);

    // T3: round-robin from IDLE after A owned last
    a_req = 1;
    run(3);
    idle_all();
    run(2);
    a_req = 1; b_req = 1;
    run(1);
    cyc_chk();
    chk("t3_b_first", 1, b_gnt_o[1], 1);
    chk("t3_a_waits", 1, a_gnt_o[1], 0);
    chk("t3_a_prio", 0, a_gnt_o[0], 1);
    cyc_end();
    idle_all();
    run(3);

    // T5: A's last read beat still returns to A after switch to B (latency 2)
    a_req = 1; a_rd = 1; a_addr = 30'h11;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) b_req = 1;
      cyc_chk();
      if (i == 3) chk("t5_last_a_read", 1, s_rd_o[1] & a_gnt_o[1], 1);
      if (i == 5) begin
        chk("t5_a_rvalid", 1, a_rv_o[1], 1);
        chk("t5_b_rvalid", 1, b_rv_o[1], 0);
        chk("t5_b_gnt", 1, b_gnt_o[1], 1);
      end
      cyc_end();
    end
    idle_all();
    run(2);

    // T6: asynchronous reset between read beat and response
    a_req = 1; a_rd = 1; a_addr = 30'h12;
    run(2);
    cyc_chk();
    chk("t6_pre_rvalid", 0, a_rv_o[0], 1);
    async_reset();
    idle_all();
    run(6);

    // Randomised traffic against the model, with one mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) a_req = ~a_req;
      if ($urandom_range(0, 3) == 0) b_req = ~b_req;
      a_we = ($urandom_range(0, 3) == 0); a_rd = 1'($urandom_range(0, 1));
      b_we = ($urandom_range(0, 3) == 0); b_rd = 1'($urandom_range(0, 1));
      a_addr = AW'($urandom); b_addr = AW'($urandom);
      a_mask = 4'($urandom); b_mask = 4'($urandom);
      a_wdata = $urandom; b_wdata = $urandom;
      cyc_chk();
      if (i == 1500) async_reset();
      else cyc_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequential two-master arbiter that shares the single memory bus (data RAM plus UART slave mux) between the debug probe (master A) and the multicycle core (master B).
- It replaces the static probe/CPU select with a request/grant handshake, fair rotation and a burst limit.
- It routes each read response back to the master that issued the read.
- It sits between the masters and the slave bus mux.

Parameters:
- ADDR_W, 30: word-address width.
- READ_LATENCY, 1: cycles from a read beat on the slave side to valid slave_rdata (range 1..4).
- MAX_BURST, 8: maximum consecutive beats for one owner while the other master is requesting (range 1..255).
- A_PRIORITY, 1: 1 = master A wins a simultaneous request from IDLE; 0 = round-robin from IDLE.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- a_req  in  1  master A requests or holds the bus
- a_addr  in  ADDR_W  master A word address
- a_we  in  1  master A write
- a_rd  in  1  master A read
- a_mask  in  4  master A byte mask
- a_wdata  in  32  master A write data
- a_gnt  out  1  master A owns the bus this cycle
- a_rvalid  out  1  read data for master A valid this cycle
- b_req, b_addr, b_we, b_rd, b_mask, b_wdata, b_gnt, b_rvalid: same as the master A ports, for master B
- rdata  out  32  read data, broadcast to both masters
- s_addr  out  ADDR_W  slave address
- s_we  out  1  slave write strobe
- s_rd  out  1  slave read strobe
- s_mask  out  4  slave byte mask
- s_wdata  out  32  slave write data
- s_rdata  in  32  slave read data

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - state = IDLE, burst_cnt = 0, last_owner = B, response pipe cleared.
  - All outputs 0: a_gnt, b_gnt, a_rvalid, b_rvalid, s_we, s_rd.
  - s_addr, s_mask and s_wdata read as 0.
- State machine: registered state IDLE / OWN_A / OWN_B.
  - a_gnt = (state == OWN_A); b_gnt = (state == OWN_B). Both are registered, so a grant appears no earlier than the cycle after the request.
- IDLE transitions:
  - Only A requesting -> OWN_A. Only B requesting -> OWN_B.
  - Both requesting: if A_PRIORITY = 1 -> OWN_A; otherwise go to the master that is not last_owner.
  - Neither requesting -> stay in IDLE.
- OWN_X (X is the owner, Y the other master):
  - Beat: a cycle with X_gnt & X_req.
  - burst_cnt increments per beat and saturates at MAX_BURST.
  - X_req = 0 -> OWN_Y if Y_req = 1, else IDLE.
  - X_req = 1, Y_req = 1 and burst_cnt == MAX_BURST-1 on a beat -> OWN_Y directly, with no idle bubble.
  - Otherwise stay in OWN_X.
  - Every change of owner sets burst_cnt = 0 and last_owner = X.
- Command path (combinational from the owner's inputs):
  - s_addr, s_mask and s_wdata are the owner's signals; all three are 0 in IDLE.
  - s_we = gnt & req & we; s_rd = gnt & req & rd.
  - A master without a grant never reaches the slave.
  - A master asserting both rd and we is a protocol error: the write wins and s_rd is forced to 0.
- Response path:
  - A pipe of depth READ_LATENCY carries (valid, id) for each read beat.
  - At the output of the pipe, X_rvalid = valid & (id == X).
  - rdata = s_rdata, passed through combinationally.
  - Responses stay correctly tagged across an ownership switch: a read issued by A in its last beat returns as a_rvalid even while b_gnt is high.
- Back-to-back reads: one read per cycle is allowed; responses return in order, one per cycle.
- Reset mid-operation: in-flight responses are discarded and no rvalid is produced after reset is released; the arbiter restarts from IDLE.
- A master dropping req while its read is in flight still receives its rvalid.

Test Plan:
1. Reset, then a_req = 1 with a read at a_addr = 0x10 from IDLE -> a_gnt = 1 at cycle t+1, s_rd = 1 with s_addr = 0x10 at t+1, a_rvalid = 1 with rdata = RAM[0x10] at t+2 (READ_LATENCY = 1).
2. a_req and b_req rise together from IDLE with A_PRIORITY = 1 -> OWN_A. A holds req with MAX_BURST = 8 -> exactly 8 beats for A, then b_gnt = 1 on the very next cycle with no IDLE cycle.
3. A_PRIORITY = 0, last_owner = A, both requesting from IDLE -> b_gnt = 1 first.
4. B writes 0xDEADBEEF with b_mask = 4'b0011 to 0x40, then A reads 0x40 -> s_we is high for exactly one cycle and a_rvalid returns 0x0000BEEF (assuming the RAM held 0 at 0x40).
5. Ownership switch with a read in flight, READ_LATENCY = 2 -> a_rvalid (not b_rvalid) two cycles after A's last read beat, while b_gnt = 1.
6. rst asserted asynchronously between a read beat and its response -> all grants and rvalids drop immediately, and no rvalid appears after release.
